// File: rtl/cpu_ctrl_fsm.sv
//==============================================================================
// Module      : cpu_ctrl_fsm
// Description : Multi-cycle control sequencer. Steps each instruction through
//               FETCH, DECODE, EXEC, MEM and WB. The one-hot operation class
//               latched in DECODE selects the path. The block drives the
//               datapath and memory-port enables.
//               Optional feature macro: CTRL_TRAP_EN. When it is defined, an
//               illegal class traps. When it is undefined, an illegal class
//               executes as a NOP.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_class,
    input  logic       cond_true,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       flags_we,
    output logic       sp_inc,
    output logic       sp_dec,
    output logic       retire,
    output logic       illegal
);

    // Bit positions of the decoder class flags
    localparam int c_ALU  = 0;
    localparam int c_CMP  = 1;
    localparam int c_JMP  = 2;
    localparam int c_LD   = 3;
    localparam int c_STR  = 4;
    localparam int c_CALL = 5;
    localparam int c_RET  = 6;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_op_q;
    logic       w_illegal_op;

    logic       w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_we, w_pc_we;
    logic [1:0] w_pc_sel;
    logic       w_reg_we, w_wb_sel, w_flags_we, w_sp_inc, w_sp_dec, w_retire;

    // A legal class has exactly one flag set.
    assign w_illegal_op = (r_op_q == 7'd0) || ((r_op_q & (r_op_q - 7'd1)) != 7'd0);

    // State register and latch of the class flags at DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op_q  <= 7'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= op_class;
            end
        end
    end

`ifdef CTRL_TRAP_EN
    logic r_illegal;

    // Sticky illegal flag. It is set on entry to TRAP and only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_EXEC && w_illegal_op) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Next-state and enable decode. mem_req and mem_addr_sel depend on state only.
    always_comb begin
        w_next         = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = 2'd0;
        w_reg_we       = 1'b0;
        w_wb_sel       = 1'b0;
        w_flags_we     = 1'b0;
        w_sp_inc       = 1'b0;
        w_sp_dec       = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_illegal_op) begin
`ifdef CTRL_TRAP_EN
                    w_next   = S_TRAP;
`else
                    w_pc_we  = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
`endif
                end else if (r_op_q[c_ALU]) begin
                    w_next = S_WB;
                end else if (r_op_q[c_CMP]) begin
                    w_flags_we = 1'b1;
                    w_pc_we    = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else if (r_op_q[c_JMP]) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = cond_true ? 2'd1 : 2'd0;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = r_op_q[c_STR] | r_op_q[c_CALL];
                if (mem_ready) begin
                    if (r_op_q[c_LD]) begin
                        w_next = S_WB;
                    end else if (r_op_q[c_STR]) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else if (r_op_q[c_CALL]) begin
                        w_sp_dec = 1'b1;
                        w_pc_we  = 1'b1;
                        w_pc_sel = 2'd1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        // Return: pop the stack and load the PC from read data.
                        w_sp_inc = 1'b1;
                        w_pc_we  = 1'b1;
                        w_pc_sel = 2'd2;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_wb_sel = r_op_q[c_LD];
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
`ifdef CTRL_TRAP_EN
                w_next = S_TRAP;
`else
                w_next = S_FETCH;
`endif
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // While reset is low, force every output to 0 without waiting for a clock edge.
    assign state        = r_state;
    assign mem_req      = rst_n & w_mem_req;
    assign mem_we       = rst_n & w_mem_we;
    assign mem_addr_sel = rst_n & w_mem_addr_sel;
    assign ir_we        = rst_n & w_ir_we;
    assign pc_we        = rst_n & w_pc_we;
    assign pc_sel       = rst_n ? w_pc_sel : 2'd0;
    assign reg_we       = rst_n & w_reg_we;
    assign wb_sel       = rst_n & w_wb_sel;
    assign flags_we     = rst_n & w_flags_we;
    assign sp_inc       = rst_n & w_sp_inc;
    assign sp_dec       = rst_n & w_sp_dec;
    assign retire       = rst_n & w_retire;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
//==============================================================================
// Module      : tb_cpu_ctrl_fsm
// Description : Self-checking bench for cpu_ctrl_fsm. A scoreboard queue holds
//               the expected output vector of each cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op_class;
    logic       cond_true;
    logic       mem_ready;
    logic [2:0] state;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       reg_we, wb_sel, flags_we, sp_inc, sp_dec, retire, illegal;

    int n_total = 0;
    int n_bad   = 0;

    logic [16:0] sb_q[$];
    string       tag_q[$];

    cpu_ctrl_fsm u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_class     (op_class),
        .cond_true    (cond_true),
        .mem_ready    (mem_ready),
        .state        (state),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .flags_we     (flags_we),
        .sp_inc       (sp_inc),
        .sp_dec       (sp_dec),
        .retire       (retire),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [16:0] w_obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                         reg_we, wb_sel, flags_we, sp_inc, sp_dec, retire, illegal};

    function automatic logic [16:0] mk(input logic [2:0] st, input logic req, input logic we,
                                       input logic asel, input logic irwe, input logic pcwe,
                                       input logic [1:0] pcsel, input logic regwe, input logic wbsel,
                                       input logic flwe, input logic spi, input logic spd,
                                       input logic ret, input logic ill);
        return {st, req, we, asel, irwe, pcwe, pcsel, regwe, wbsel, flwe, spi, spd, ret, ill};
    endfunction

    task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b (st,req,we,asel,irwe,pcwe,pcsel,regwe,wbsel,flwe,spi,spd,ret,ill)",
                     tag, got, exp);
        end
    endtask

    // Push an expectation and compare it immediately against the current outputs
    task automatic sb_check(input string tag, input logic [16:0] exp);
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        check_val(tag_q.pop_front(), w_obs, sb_q.pop_front());
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge
    task automatic step(input logic rdy, input logic [6:0] op, input logic cnd,
                        input logic [16:0] exp, input string tag);
        mem_ready = rdy;
        op_class  = op;
        cond_true = cnd;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        check_val(tag_q.pop_front(), w_obs, sb_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    // Run one instruction. fw and mw are the wait cycles in FETCH and MEM.
    task automatic run_instr(input logic [6:0] op, input logic cnd, input int fw, input int mw);
        logic [6:0] junk;
        logic       we;
        logic       legal;
        junk  = ~op;
        legal = ($countones(op) == 1);
        we    = op[4] | op[5];
        for (int i = 0; i < fw; i++)
            step(1'b0, 7'($urandom), ~cnd, mk(3'd0,1,0,0,0,0,2'd0,0,0,0,0,0,0,0), "fetch_wait");
        step(1'b1, 7'($urandom), ~cnd, mk(3'd0,1,0,0,1,0,2'd0,0,0,0,0,0,0,0), "fetch_rdy");
        step(1'($urandom), op, ~cnd, mk(3'd1,0,0,0,0,0,2'd0,0,0,0,0,0,0,0), "decode");
        if (!legal) begin
`ifdef CTRL_TRAP_EN
            step(1'b1, junk, cnd, mk(3'd2,0,0,0,0,0,2'd0,0,0,0,0,0,0,0), "exec_illegal");
            for (int i = 0; i < 3; i++)
                step(1'b1, junk, cnd, mk(3'd5,0,0,0,0,0,2'd0,0,0,0,0,0,0,1), "trap_hold");
`else
            step(1'b1, junk, cnd, mk(3'd2,0,0,0,0,1,2'd0,0,0,0,0,0,1,0), "exec_nop");
`endif
        end else if (op[0]) begin
            step(1'b1, junk, cnd, mk(3'd2,0,0,0,0,0,2'd0,0,0,0,0,0,0,0), "exec_alu");
            step(1'b0, junk, cnd, mk(3'd4,0,0,0,0,1,2'd0,1,0,0,0,0,1,0), "wb_alu");
        end else if (op[1]) begin
            step(1'b0, junk, cnd, mk(3'd2,0,0,0,0,1,2'd0,0,0,1,0,0,1,0), "exec_cmp");
        end else if (op[2]) begin
            step(1'b0, junk, cnd, mk(3'd2,0,0,0,0,1,{1'b0,cnd},0,0,0,0,0,1,0), "exec_jmp");
        end else begin
            step(1'b1, junk, cnd, mk(3'd2,0,0,0,0,0,2'd0,0,0,0,0,0,0,0), "exec_mem");
            for (int i = 0; i < mw; i++)
                step(1'b0, 7'($urandom), cnd, mk(3'd3,1,we,1,0,0,2'd0,0,0,0,0,0,0,0), "mem_wait");
            if (op[3]) begin
                step(1'b1, junk, cnd, mk(3'd3,1,0,1,0,0,2'd0,0,0,0,0,0,0,0), "mem_ld");
                step(1'b1, junk, cnd, mk(3'd4,0,0,0,0,1,2'd0,1,1,0,0,0,1,0), "wb_ld");
            end else if (op[4]) begin
                step(1'b1, junk, cnd, mk(3'd3,1,1,1,0,1,2'd0,0,0,0,0,0,1,0), "mem_str");
            end else if (op[5]) begin
                step(1'b1, junk, cnd, mk(3'd3,1,1,1,0,1,2'd1,0,0,0,0,1,1,0), "mem_call");
            end else begin
                step(1'b1, junk, cnd, mk(3'd3,1,0,1,0,1,2'd2,0,0,0,1,0,1,0), "mem_ret");
            end
        end
    endtask

    // Assert reset mid-cycle, check that the outputs clear at once, then release
    task automatic mid_reset();
        #2;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        sb_check("rst_async", 17'd0);
        @(posedge clk);
        #1;
        sb_check("rst_hold", 17'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        sb_check("rst_release", mk(3'd0,1,0,0,0,0,2'd0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        op_class  = 7'd0;
        cond_true = 1'b0;
        #1;
        sb_check("reset_state", 17'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(7'b0000001, 1'b0, 0, 0);   // alu
        run_instr(7'b0001000, 1'b0, 0, 3);   // ld with 3 wait cycles in MEM
        run_instr(7'b0000100, 1'b1, 0, 0);   // jmp taken
        run_instr(7'b0000100, 1'b0, 0, 0);   // jmp not taken
        run_instr(7'b0100000, 1'b0, 0, 0);   // call
        run_instr(7'b1000000, 1'b0, 0, 0);   // ret
        run_instr(7'b0010000, 1'b1, 2, 1);   // str with waits
        run_instr(7'b0000010, 1'b0, 1, 0);   // cmp
        run_instr(7'b0001000, 1'b1, 0, 0);   // ld, zero wait
        run_instr(7'b0100000, 1'b1, 1, 2);   // call with waits

        // Reset while FETCH is waiting with mem_req high
        step(1'b0, 7'd0, 1'b0, mk(3'd0,1,0,0,0,0,2'd0,0,0,0,0,0,0,0), "fetch_wait_pre_rst");
        mid_reset();
        run_instr(7'b0000001, 1'b1, 1, 0);   // alu after reset

        // Illegal classes
        run_instr(7'b0000011, 1'b0, 0, 0);
`ifdef CTRL_TRAP_EN
        mid_reset();
`endif
        run_instr(7'b0000000, 1'b0, 0, 0);
`ifdef CTRL_TRAP_EN
        mid_reset();
`endif
        run_instr(7'b0000100, 1'b1, 0, 0);   // jmp after illegal handling

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
